craps_controller: RTL
=====================

Name: craps_controller

Overview:
- Game controller that sits on the initiator side of two `die` instances.
- Drives their shared `roll` input from a player button, waits for the dice to settle, then samples both 4-bit values.
- Applies craps rules across one or more rolls and reports win/lose/point status to the board LEDs and display.

Parameters:
MIN_ROLL  4  minimum number of cycles `roll` stays high per throw (1..255)
SETTLE    2  cycles after `roll` falls before die values are sampled (1..15)

Ports:
clock   input   1  system clock, all logic on rising edge
reset   input   1  synchronous, active-low reset
button  input   1  player throw button, already synchronized and debounced, level-sensitive
die_a   input   4  value from die A, legal 1..6
die_b   input   4  value from die B, legal 1..6
roll    output  1  roll enable to both die instances
sum     output  4  last sampled die_a+die_b (2..12)
point   output  4  established point, 0 = no point yet
rolls   output  8  throws in current game, saturates at 255
win     output  1  game won, held until next game
lose    output  1  game lost, held until next game
err     output  1  illegal die value sampled, sticky until reset

Behaviour:
- Reset (reset==0 at a clock edge):
  - roll=0, sum=0, point=0, rolls=0, win=0, lose=0, err=0.
  - State=IDLE; roll counter and settle counter cleared.
  - Reset overrides every state, including mid-throw: roll is low on the cycle after the edge.
- Button edge: `button` is registered once; a rise is btn_q==0 and button==1. Only rises start throws.
- States: IDLE, ROLLING, SETTLING, EVAL, DONE, ERROR.
- IDLE -> ROLLING on a button rise. From that edge onward:
  - roll=1.
  - roll counter loaded with 1.
  - rolls increments, saturating at 255.
- ROLLING:
  - roll=1 and the counter increments each cycle, saturating at MIN_ROLL.
  - Leave when button==0 and counter>=MIN_ROLL. roll=0 from the next edge; go to SETTLING.
  - A button that is already released gives exactly MIN_ROLL roll-high cycles.
- SETTLING: count SETTLE cycles with roll=0, then go to EVAL.
- EVAL lasts one cycle:
  - Sample die_a and die_b.
  - If either value is 0 or >6: err=1, state ERROR; sum and point are unchanged.
  - Otherwise sum = die_a+die_b, 4-bit with no overflow possible.
- Come-out roll (point==0):
  - sum 7 or 11 -> win=1, DONE.
  - sum 2, 3 or 12 -> lose=1, DONE.
  - Any other sum -> point=sum, IDLE.
- Point roll (point!=0):
  - sum==point -> win=1, DONE.
  - sum==7 -> lose=1, DONE.
  - Otherwise -> IDLE, point held.
- sum, win and lose update on the same edge that leaves EVAL.
- DONE: outputs held. A button rise starts a new game on one edge:
  - win=0, lose=0, point=0, rolls=1.
  - roll=1, enter ROLLING.
  - sum is kept until the next EVAL.
- ERROR: roll=0, all outputs frozen; only reset exits.
- Buttons ignored: rises in ROLLING, SETTLING or EVAL are ignored, and a held button does not retrigger.
- win and lose are never both 1.
- Throw latency: from the button-rise edge to the result edge is
  max(MIN_ROLL, button-high cycles) + SETTLE + 1 cycles.

Test Plan:
1. **Reset then first throw.** Reset low 2 cycles, then button pulse 1 cycle with defaults.
   - roll is high exactly 4 cycles, then low.
   - Die sampled 3 cycles after roll falls.
   - rolls=1.
2. **Come-out results.** Force die_a=3, die_b=4 at EVAL -> sum=7, win=1, lose=0, point=0. New game with 1+1 -> win cleared, lose=1, sum=2, rolls=1.
3. **Point established, then made.**
   - Come-out 2+2 -> point=4, win=lose=0.
   - Next throw 5+1 -> sum=6, still IDLE, rolls=2.
   - Next throw 3+1 -> win=1, rolls=3.
4. **Seven-out.** Point 6 established; next throw 4+3 -> lose=1, point stays 6.
5. **Long hold and illegal value.**
   - Button held 10 cycles -> roll high 10 cycles.
   - Then die_a=7 at EVAL -> err=1, roll=0.
   - Further button presses produce no roll until reset low, after which all outputs are 0.
6. **Reset mid-throw.** reset=0 while in ROLLING, 2 cycles after the button rise -> roll=0 and rolls=0 on the next edge, state IDLE; a subsequent throw behaves as in scenario 1.

Source files
------------

// File: rtl/craps_controller.sv
// Craps game controller: drives the shared roll enable of two dice, samples them
// after they settle, and tracks come-out / point rules across throws.
module craps_controller #(
    parameter int MIN_ROLL = 4,
    parameter int SETTLE   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [3:0] die_a,
    input  logic [3:0] die_b,
    output logic       roll,
    output logic [3:0] sum,
    output logic [3:0] point,
    output logic [7:0] rolls,
    output logic       win,
    output logic       lose,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ROLLING,
        SETTLING,
        EVAL,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] MIN_ROLL_C  = 8'(MIN_ROLL);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic       btn_q;
    logic [7:0] roll_cnt;
    logic [3:0] settle_cnt;
    logic       rise;
    logic [3:0] die_sum;
    logic       die_bad;

    assign rise    = button & ~btn_q;
    // Legal faces are 1..6, so the sum never exceeds 12 and fits in 4 bits.
    assign die_sum = die_a + die_b;
    assign die_bad = (die_a == 4'd0) || (die_a > 4'd6) ||
                     (die_b == 4'd0) || (die_b > 4'd6);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; reset is synchronous and checked first so it wins
    // over every state, including a throw in progress.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            btn_q      <= 1'b0;
            roll_cnt   <= 8'd0;
            settle_cnt <= 4'd0;
            roll       <= 1'b0;
            sum        <= 4'd0;
            point      <= 4'd0;
            rolls      <= 8'd0;
            win        <= 1'b0;
            lose       <= 1'b0;
            err        <= 1'b0;
        end else begin
            btn_q <= button;
            case (state)
                IDLE: begin
                    if (rise) begin
                        roll     <= 1'b1;
                        roll_cnt <= 8'd1;
                        rolls    <= (rolls == 8'hFF) ? rolls : rolls + 8'd1;
                        state    <= ROLLING;
                    end
                end
                ROLLING: begin
                    // Roll lasts at least MIN_ROLL cycles, longer while the button is held.
                    if (!button && roll_cnt >= MIN_ROLL_C) begin
                        roll       <= 1'b0;
                        settle_cnt <= 4'd0;
                        state      <= SETTLING;
                    end else if (roll_cnt < MIN_ROLL_C) begin
                        roll_cnt <= roll_cnt + 8'd1;
                    end
                end
                SETTLING: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= EVAL;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                EVAL: begin
                    if (die_bad) begin
                        err   <= 1'b1;
                        state <= ERROR;
                    end else begin
                        sum <= die_sum;
                        if (point == 4'd0) begin
                            if (die_sum == 4'd7 || die_sum == 4'd11) begin
                                win   <= 1'b1;
                                state <= DONE;
                            end else if (die_sum == 4'd2 || die_sum == 4'd3 ||
                                         die_sum == 4'd12) begin
                                lose  <= 1'b1;
                                state <= DONE;
                            end else begin
                                point <= die_sum;
                                state <= IDLE;
                            end
                        end else if (die_sum == point) begin
                            win   <= 1'b1;
                            state <= DONE;
                        end else if (die_sum == 4'd7) begin
                            lose  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    // A rise here both clears the finished game and starts its first throw.
                    if (rise) begin
                        win      <= 1'b0;
                        lose     <= 1'b0;
                        point    <= 4'd0;
                        rolls    <= 8'd1;
                        roll     <= 1'b1;
                        roll_cnt <= 8'd1;
                        state    <= ROLLING;
                    end
                end
                ERROR: begin
                    roll <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
